// File: rtl/us_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : us_tx_pkg
// Brief   : Shared state encoding and default widths for the ultrasonic
//           burst transmitter.
// Revision: 1.0 - initial release
// ============================================================================
package us_tx_pkg;

  // Default widths of the time base, half-period field and pulse-count field
  localparam int DEFAULT_TIME_W = 32;
  localparam int DEFAULT_HP_W   = 16;
  localparam int DEFAULT_NP_W   = 8;

  // Burst sequencer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_HIGH = 3'd2,
    ST_LOW  = 3'd3,
    ST_DONE = 3'd4
  } tx_state_t;

endpackage : us_tx_pkg
`default_nettype wire

// File: rtl/us_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module  : us_pulse_gen
// Brief   : Carrier generator. On start, drives hp cycles high then hp cycles
//           low, repeated np times. A zero half-period is treated as one.
// Revision: 1.0 - initial release
// ============================================================================
module us_pulse_gen
  import us_tx_pkg::*;
#(
  parameter int HP_W = DEFAULT_HP_W,
  parameter int NP_W = DEFAULT_NP_W
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [HP_W-1:0] hp,
  input  logic [NP_W-1:0] np,
  input  logic            abort,
  output logic            out,
  output logic            phase_end,
  output logic            last
);

  logic            active;
  logic [HP_W-1:0] hp_eff;
  logic [HP_W-1:0] hp_lat;
  logic [HP_W-1:0] phase_cnt;
  logic [NP_W-1:0] period_cnt;

  assign hp_eff = (hp == '0) ? HP_W'(1) : hp;

  // phase_cnt counts down the cycles left in the current phase, so the final
  // cycle of any phase is where it reads one.
  assign phase_end = active && (phase_cnt == HP_W'(1));
  assign last      = phase_end && !out && (period_cnt == NP_W'(1));

  // Phase/period counting with the drive bit held in a register
  always_ff @(posedge clock) begin
    if (reset || abort) begin
      out        <= 1'b0;
      active     <= 1'b0;
      hp_lat     <= '0;
      phase_cnt  <= '0;
      period_cnt <= '0;
    end else if (start) begin
      hp_lat     <= hp_eff;
      phase_cnt  <= hp_eff;
      period_cnt <= np;
      out        <= (np != '0);
      active     <= (np != '0);
    end else if (active) begin
      if (phase_cnt == HP_W'(1)) begin
        if (out) begin
          out       <= 1'b0;
          phase_cnt <= hp_lat;
        end else if (period_cnt == NP_W'(1)) begin
          active     <= 1'b0;
          phase_cnt  <= '0;
          period_cnt <= '0;
        end else begin
          out        <= 1'b1;
          phase_cnt  <= hp_lat;
          period_cnt <= period_cnt - NP_W'(1);
        end
      end else begin
        phase_cnt <= phase_cnt - HP_W'(1);
      end
    end
  end

endmodule : us_pulse_gen
`default_nettype wire

// File: rtl/us_burst_tx.sv
`default_nettype none
// ============================================================================
// Module  : us_burst_tx
// Brief   : Time-scheduled ultrasonic burst transmitter. A burst is armed
//           with a fire time against a wrapping time base, waits, stamps the
//           fire time and then drives a square-wave carrier.
// Revision: 1.0 - initial release
// ============================================================================
module us_burst_tx
  import us_tx_pkg::*;
#(
  parameter int TIME_W = DEFAULT_TIME_W,
  parameter int HP_W   = DEFAULT_HP_W,
  parameter int NP_W   = DEFAULT_NP_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [TIME_W-1:0] time_cnt,
  input  logic              arm,
  input  logic [TIME_W-1:0] start_time,
  input  logic [HP_W-1:0]   half_period,
  input  logic [NP_W-1:0]   num_pulses,
  input  logic              abort,
  output logic              burst_out,
  output logic              busy,
  output logic [TIME_W-1:0] tx_time_stamp,
  output logic              tx_done,
  output logic              missed
);

  tx_state_t         state;
  logic [TIME_W-1:0] cfg_start;
  logic [HP_W-1:0]   cfg_hp;
  logic [NP_W-1:0]   cfg_np;

  logic [TIME_W-1:0] arm_diff;
  logic [TIME_W-1:0] wait_diff;
  logic              wait_due;
  logic              fire;
  logic              phase_end;
  logic              last;

  // Distances to the target are read as signed so a target ahead of a
  // wrapping time base still looks like the future.
  assign arm_diff  = start_time - time_cnt;
  assign wait_diff = cfg_start - time_cnt;
  assign wait_due  = wait_diff[TIME_W-1] || (wait_diff == '0);
  assign fire      = (state == ST_WAIT) && wait_due && !abort;

  us_pulse_gen #(
    .HP_W (HP_W),
    .NP_W (NP_W)
  ) u_pulse_gen (
    .clock     (clock),
    .reset     (reset),
    .start     (fire),
    .hp        (cfg_hp),
    .np        (cfg_np),
    .abort     (abort),
    .out       (burst_out),
    .phase_end (phase_end),
    .last      (last)
  );

  // Burst sequencer: scheduling, fire stamping and completion handshakes
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      tx_done       <= 1'b0;
      missed        <= 1'b0;
      tx_time_stamp <= '0;
      cfg_start     <= '0;
      cfg_hp        <= '0;
      cfg_np        <= '0;
    end else begin
      tx_done <= 1'b0;
      missed  <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (arm && (num_pulses != '0)) begin
              if (arm_diff[TIME_W-1]) begin
                missed <= 1'b1;
              end else begin
                cfg_start <= start_time;
                cfg_hp    <= half_period;
                cfg_np    <= num_pulses;
                state     <= ST_WAIT;
                busy      <= 1'b1;
              end
            end
          end
          ST_WAIT: begin
            if (wait_due) begin
              tx_time_stamp <= time_cnt;
              state         <= ST_HIGH;
            end
          end
          ST_HIGH: begin
            if (phase_end) state <= ST_LOW;
          end
          ST_LOW: begin
            if (last) begin
              state   <= ST_DONE;
              tx_done <= 1'b1;
            end else if (phase_end) begin
              state <= ST_HIGH;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule : us_burst_tx
`default_nettype wire

// File: tb/tb_us_burst_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_us_burst_tx
// Brief   : Self-checking bench for us_burst_tx: directed scenarios plus
//           randomized bursts checked against a schedule-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_us_burst_tx;

  localparam int TIME_W = 32;
  localparam int HP_W   = 16;
  localparam int NP_W   = 8;
  localparam int MAXC   = 160;

  logic              clock = 1'b0;
  logic              reset;
  logic              arm;
  logic              abort;
  logic [TIME_W-1:0] time_cnt;
  logic [TIME_W-1:0] start_time;
  logic [HP_W-1:0]   half_period;
  logic [NP_W-1:0]   num_pulses;
  logic              burst_out;
  logic              busy;
  logic              tx_done;
  logic              missed;
  logic [TIME_W-1:0] tx_time_stamp;

  int checks = 0;
  int errors = 0;
  logic [TIME_W-1:0] exp_stamp;

  logic              cap_out   [MAXC];
  logic              cap_busy  [MAXC];
  logic              cap_done  [MAXC];
  logic              cap_miss  [MAXC];
  logic [TIME_W-1:0] cap_stamp [MAXC];

  us_burst_tx #(
    .TIME_W (TIME_W),
    .HP_W   (HP_W),
    .NP_W   (NP_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .time_cnt      (time_cnt),
    .arm           (arm),
    .start_time    (start_time),
    .half_period   (half_period),
    .num_pulses    (num_pulses),
    .abort         (abort),
    .burst_out     (burst_out),
    .busy          (busy),
    .tx_time_stamp (tx_time_stamp),
    .tx_done       (tx_done),
    .missed        (missed)
  );

  always #5 clock = ~clock;

  // One clock: requests are single-cycle, the time base advances by one
  task automatic step();
    @(posedge clock);
    #1;
    arm      = 1'b0;
    abort    = 1'b0;
    time_cnt = time_cnt + TIME_W'(1);
  endtask

  // Record outputs for observation cycles from..to
  task automatic collect(input int from, input int to);
    for (int j = from; j <= to; j++) begin
      step();
      cap_out[j]   = burst_out;
      cap_busy[j]  = busy;
      cap_done[j]  = tx_done;
      cap_miss[j]  = missed;
      cap_stamp[j] = tx_time_stamp;
    end
  endtask

  task automatic issue_arm(input logic [TIME_W-1:0] st, input int hp, input int np);
    start_time  = st;
    half_period = HP_W'(hp);
    num_pulses  = NP_W'(np);
    arm         = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    issue_arm(time_cnt + TIME_W'(5), 2, 2);
    repeat (3) step();
    reset = 1'b0;
    exp_stamp = '0;
    checks++; if (burst_out !== 1'b0) begin errors++; $display("FAIL reset_out got %b want 0", burst_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", tx_done); end
    checks++; if (missed !== 1'b0) begin errors++; $display("FAIL reset_missed got %b want 0", missed); end
    checks++; if (tx_time_stamp !== '0) begin errors++; $display("FAIL reset_stamp got %h want 0", tx_time_stamp); end
  endtask

  task automatic test_example();
    logic [11:0] pat;
    int ndone;
    time_cnt = 100;
    issue_arm(32'd105, 2, 3);
    collect(1, 20);
    for (int k = 0; k < 12; k++) pat[11-k] = cap_out[6+k];
    ndone = 0;
    for (int j = 1; j <= 20; j++) if (cap_done[j] === 1'b1) ndone++;
    exp_stamp = 32'd105;
    checks++; if (cap_busy[1] !== 1'b1) begin errors++; $display("FAIL ex_wait_busy got %b want 1", cap_busy[1]); end
    checks++; if (cap_out[5] !== 1'b0) begin errors++; $display("FAIL ex_pre_fire got %b want 0", cap_out[5]); end
    checks++; if (pat !== 12'b110011001100) begin errors++; $display("FAIL ex_pattern got %b want 110011001100", pat); end
    checks++; if (cap_done[18] !== 1'b1) begin errors++; $display("FAIL ex_done got %b want 1", cap_done[18]); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL ex_done_count got %0d want 1", ndone); end
    checks++; if (cap_busy[19] !== 1'b0) begin errors++; $display("FAIL ex_idle_busy got %b want 0", cap_busy[19]); end
    checks++; if (cap_stamp[20] !== exp_stamp) begin errors++; $display("FAIL ex_stamp got %0d want %0d", cap_stamp[20], exp_stamp); end
  endtask

  task automatic test_missed();
    int nb, no;
    time_cnt = 50;
    issue_arm(32'd40, 3, 2);
    collect(1, 8);
    nb = 0; no = 0;
    for (int j = 1; j <= 8; j++) begin
      if (cap_busy[j] !== 1'b0) nb++;
      if (cap_out[j] !== 1'b0) no++;
    end
    checks++; if (cap_miss[1] !== 1'b1) begin errors++; $display("FAIL miss_pulse got %b want 1", cap_miss[1]); end
    checks++; if (cap_miss[2] !== 1'b0) begin errors++; $display("FAIL miss_single got %b want 0", cap_miss[2]); end
    checks++; if (nb != 0) begin errors++; $display("FAIL miss_busy got %0d busy cycles want 0", nb); end
    checks++; if (no != 0) begin errors++; $display("FAIL miss_out got %0d drive cycles want 0", no); end
    checks++; if (cap_stamp[8] !== exp_stamp) begin errors++; $display("FAIL miss_stamp got %0d want %0d", cap_stamp[8], exp_stamp); end
  endtask

  task automatic test_wrap();
    time_cnt = 32'hFFFF_FFFE;
    issue_arm(32'h0000_0002, 1, 1);
    collect(1, 9);
    exp_stamp = 32'd2;
    checks++; if (cap_out[4] !== 1'b0) begin errors++; $display("FAIL wrap_early got %b want 0", cap_out[4]); end
    checks++; if (cap_out[5] !== 1'b1) begin errors++; $display("FAIL wrap_high got %b want 1", cap_out[5]); end
    checks++; if (cap_out[6] !== 1'b0) begin errors++; $display("FAIL wrap_low got %b want 0", cap_out[6]); end
    checks++; if (cap_done[7] !== 1'b1) begin errors++; $display("FAIL wrap_done got %b want 1", cap_done[7]); end
    checks++; if (cap_stamp[9] !== exp_stamp) begin errors++; $display("FAIL wrap_stamp got %h want %h", cap_stamp[9], exp_stamp); end
  endtask

  task automatic test_abort();
    logic [TIME_W-1:0] t0;
    int nd, nb;
    t0 = $urandom;
    time_cnt = t0;
    issue_arm(t0 + TIME_W'(3), 3, 3);
    collect(1, 11);
    abort = 1'b1;
    collect(12, 18);
    exp_stamp = t0 + TIME_W'(3);
    nd = 0;
    for (int j = 1; j <= 18; j++) if (cap_done[j] === 1'b1) nd++;
    checks++; if (cap_out[10] !== 1'b1) begin errors++; $display("FAIL abort_second_high got %b want 1", cap_out[10]); end
    checks++; if (cap_out[12] !== 1'b0) begin errors++; $display("FAIL abort_out got %b want 0", cap_out[12]); end
    checks++; if (cap_busy[12] !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", cap_busy[12]); end
    checks++; if (nd != 0) begin errors++; $display("FAIL abort_done got %0d pulses want 0", nd); end
    checks++; if (cap_stamp[18] !== exp_stamp) begin errors++; $display("FAIL abort_stamp got %h want %h", cap_stamp[18], exp_stamp); end
    // arm together with abort in IDLE is dropped
    issue_arm(time_cnt + TIME_W'(4), 1, 1);
    abort = 1'b1;
    collect(1, 8);
    nb = 0;
    for (int j = 1; j <= 8; j++) if (cap_busy[j] !== 1'b0 || cap_out[j] !== 1'b0 || cap_miss[j] !== 1'b0) nb++;
    checks++; if (nb != 0) begin errors++; $display("FAIL abort_arm_drop got %0d active cycles want 0", nb); end
  endtask

  task automatic test_reset_midburst();
    logic [TIME_W-1:0] t0;
    int nb;
    t0 = $urandom;
    time_cnt = t0;
    issue_arm(t0 + TIME_W'(2), 2, 2);
    collect(1, 4);
    reset = 1'b1;
    issue_arm(time_cnt + TIME_W'(3), 1, 1);
    abort = 1'b1;
    step();
    reset = 1'b0;
    exp_stamp = '0;
    checks++; if (cap_out[3] !== 1'b1) begin errors++; $display("FAIL rstmid_running got %b want 1", cap_out[3]); end
    checks++; if (burst_out !== 1'b0) begin errors++; $display("FAIL rstmid_out got %b want 0", burst_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (tx_time_stamp !== exp_stamp) begin errors++; $display("FAIL rstmid_stamp got %h want 0", tx_time_stamp); end
    collect(1, 5);
    nb = 0;
    for (int j = 1; j <= 5; j++) if (cap_busy[j] !== 1'b0 || cap_done[j] !== 1'b0) nb++;
    checks++; if (nb != 0) begin errors++; $display("FAIL rstmid_after got %0d active cycles want 0", nb); end
  endtask

  task automatic test_ignore_arm();
    logic [TIME_W-1:0] t1;
    int na;
    issue_arm(time_cnt - TIME_W'(5), 2, 0);
    collect(1, 5);
    na = 0;
    for (int j = 1; j <= 5; j++)
      if (cap_busy[j] !== 1'b0 || cap_out[j] !== 1'b0 || cap_miss[j] !== 1'b0 || cap_done[j] !== 1'b0) na++;
    checks++; if (na != 0) begin errors++; $display("FAIL np0_response got %0d active cycles want 0", na); end
    t1 = time_cnt;
    issue_arm(t1 + TIME_W'(10), 1, 1);
    collect(1, 3);
    issue_arm(time_cnt + TIME_W'(1), 4, 2);
    collect(4, 14);
    exp_stamp = t1 + TIME_W'(10);
    checks++; if (cap_out[10] !== 1'b0) begin errors++; $display("FAIL rearm_early got %b want 0", cap_out[10]); end
    checks++; if (cap_out[11] !== 1'b1) begin errors++; $display("FAIL rearm_high got %b want 1", cap_out[11]); end
    checks++; if (cap_out[12] !== 1'b0) begin errors++; $display("FAIL rearm_low got %b want 0", cap_out[12]); end
    checks++; if (cap_done[13] !== 1'b1) begin errors++; $display("FAIL rearm_done got %b want 1", cap_done[13]); end
    checks++; if (cap_stamp[14] !== exp_stamp) begin errors++; $display("FAIL rearm_stamp got %h want %h", cap_stamp[14], exp_stamp); end
  endtask

  task automatic test_hp_zero();
    logic [TIME_W-1:0] t0;
    logic [3:0] pat;
    for (int hp = 0; hp <= 1; hp++) begin
      t0 = $urandom;
      time_cnt = t0;
      issue_arm(t0 + TIME_W'(2), hp, 2);
      collect(1, 9);
      exp_stamp = t0 + TIME_W'(2);
      for (int k = 0; k < 4; k++) pat[3-k] = cap_out[3+k];
      checks++; if (pat !== 4'b1010) begin errors++; $display("FAIL hp%0d_pattern got %b want 1010", hp, pat); end
      checks++; if (cap_done[7] !== 1'b1) begin errors++; $display("FAIL hp%0d_done got %b want 1", hp, cap_done[7]); end
    end
  endtask

  // Randomized bursts against a schedule model: fire offset, carrier pattern,
  // completion and optional abort point are computed from the burst rules.
  task automatic test_random(input int iters);
    for (int it = 0; it < iters; it++) begin
      logic [TIME_W-1:0] t0;
      logic [TIME_W-1:0] new_stamp;
      int d, hp_i, np_i, he, f, b, ab, len;
      logic fired;
      t0   = $urandom;
      d    = int'($urandom_range(60)) - 20;
      hp_i = int'($urandom_range(4));
      np_i = int'($urandom_range(4));
      he   = (hp_i == 0) ? 1 : hp_i;
      f    = (d < 1) ? 1 : d;
      b    = 2 * he * np_i;
      ab   = ($urandom_range(1) == 1) ? int'($urandom_range(f + b + 1, 1)) : -1;
      len  = f + b + 3;
      new_stamp = t0 + TIME_W'(f);
      fired = (np_i != 0) && (d >= 0) && (ab < 0 || f + 1 <= ab);
      time_cnt = t0;
      issue_arm(t0 + TIME_W'(d), hp_i, np_i);
      for (int j = 1; j <= len; j++) begin
        logic e_out, e_busy, e_done, e_miss;
        logic [TIME_W-1:0] e_stamp;
        step();
        e_out = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_miss = 1'b0; e_stamp = exp_stamp;
        if (np_i != 0) begin
          if (d < 0) begin
            e_miss = (j == 1);
          end else begin
            e_busy = (j <= f + b + 1);
            e_done = (j == f + b + 1);
            e_out  = (j > f) && (j <= f + b) && ((((j - f - 1) / he) % 2) == 0);
            if (j > f) e_stamp = new_stamp;
          end
        end
        if (ab >= 0 && j > ab) begin
          e_out = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_miss = 1'b0;
          e_stamp = fired ? new_stamp : exp_stamp;
        end
        checks++; if (burst_out !== e_out) begin errors++; $display("FAIL rnd_out it=%0d j=%0d got %b want %b", it, j, burst_out, e_out); end
        checks++; if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy it=%0d j=%0d got %b want %b", it, j, busy, e_busy); end
        checks++; if (tx_done !== e_done) begin errors++; $display("FAIL rnd_done it=%0d j=%0d got %b want %b", it, j, tx_done, e_done); end
        checks++; if (missed !== e_miss) begin errors++; $display("FAIL rnd_missed it=%0d j=%0d got %b want %b", it, j, missed, e_miss); end
        checks++; if (tx_time_stamp !== e_stamp) begin errors++; $display("FAIL rnd_stamp it=%0d j=%0d got %h want %h", it, j, tx_time_stamp, e_stamp); end
        if (j == ab) abort = 1'b1;
      end
      if (fired) exp_stamp = new_stamp;
    end
  endtask

  initial begin
    reset       = 1'b1;
    arm         = 1'b0;
    abort       = 1'b0;
    time_cnt    = '0;
    start_time  = '0;
    half_period = '0;
    num_pulses  = '0;
    exp_stamp   = '0;
    test_reset();
    test_example();
    test_missed();
    test_wrap();
    test_abort();
    test_reset_midburst();
    test_ignore_arm();
    test_hp_zero();
    test_random(60);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_us_burst_tx
`default_nettype wire
